// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM state encoding and default data width for the PWM controller
package pwm_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_e;
endpackage

// File: rtl/pwm_shadow_reg.sv
// pwm_shadow_reg: one-entry period/duty holding slot with valid/ready handshake
module pwm_shadow_reg import pwm_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             cfg_valid_i,
  input  logic [WIDTH-1:0] cfg_period_i,
  input  logic [WIDTH-1:0] cfg_duty_i,
  input  logic             load_i,
  output logic             cfg_ready_o,
  output logic             sh_full_o,
  output logic [WIDTH-1:0] sh_period_o,
  output logic [WIDTH-1:0] sh_duty_o
);
  logic             rdy_q, rdy_d, acc;
  logic [WIDTH-1:0] per_q, per_d, duty_q, duty_d;
  always_comb begin
    acc    = cfg_valid_i & rdy_q;
    rdy_d  = ~acc & (rdy_q | load_i);
    per_d  = acc ? cfg_period_i : per_q;
    duty_d = acc ? cfg_duty_i : duty_q;
  end
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q  <= 1'b1;
      per_q  <= '0;
      duty_q <= '0;
    end else begin
      rdy_q  <= rdy_d;
      per_q  <= per_d;
      duty_q <= duty_d;
    end
  end
  assign cfg_ready_o = rdy_q;
  assign sh_full_o   = ~rdy_q;
  assign sh_period_o = per_q;
  assign sh_duty_o   = duty_q;
endmodule

// File: rtl/pwm_ctrl.sv
// pwm_ctrl: PWM generator with shadowed period/duty applied only at period boundaries
module pwm_ctrl import pwm_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             pwm_out,
  output logic             period_end,
  output logic             busy
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, act_period_q, act_period_d, act_duty_q, act_duty_d;
  logic [WIDTH-1:0] sh_period, sh_duty;
  logic             pwm_q, pwm_d, pe_q, pe_d, busy_q, busy_d;
  logic             run, wrap, start, sh_full;
  pwm_shadow_reg #(.WIDTH(WIDTH)) u_shadow (
    .ck          (ck),
    .rst_n       (rst_n),
    .cfg_valid_i (cfg_valid),
    .cfg_period_i(cfg_period),
    .cfg_duty_i  (cfg_duty),
    .load_i      (wrap | start),
    .cfg_ready_o (cfg_ready),
    .sh_full_o   (sh_full),
    .sh_period_o (sh_period),
    .sh_duty_o   (sh_duty)
  );
  // A stop request only takes effect at the wrap, so STOP keeps counting like RUN
  always_comb begin
    run          = state_q != IDLE;
    wrap         = run && cnt_q == act_period_q;
    start        = !run && en;
    state_d      = !run ? (en ? RUN : IDLE) : en ? RUN : (state_q == STOP && wrap) ? IDLE : STOP;
    cnt_d        = (start || wrap) ? '0 : run ? cnt_q + 1'b1 : cnt_q;
    act_period_d = ((wrap || start) && sh_full) ? sh_period : act_period_q;
    act_duty_d   = ((wrap || start) && sh_full) ? sh_duty : act_duty_q;
    pwm_d        = run && cnt_q < act_duty_q;
    pe_d         = wrap;
    busy_d       = state_d != IDLE;
  end
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      act_period_q <= '0;
      act_duty_q   <= '0;
      pwm_q        <= 1'b0;
      pe_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
      pwm_q        <= pwm_d;
      pe_q         <= pe_d;
      busy_q       <= busy_d;
    end
  end
  assign pwm_out    = pwm_q;
  assign period_end = pe_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_pwm_ctrl.sv
// tb_pwm_ctrl: directed PWM scenarios checked against a period-level reference model
module tb_pwm_ctrl;
  logic       ck = 1'b0;
  logic       rst_n, en, cfg_valid, cfg_ready, pwm_out, period_end, busy;
  logic [7:0] cfg_period, cfg_duty;
  int         vec = 0, err = 0;
  bit         started = 1'b0;
  pwm_ctrl #(.WIDTH(8)) dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_period(cfg_period),
    .cfg_duty  (cfg_duty),
    .pwm_out   (pwm_out),
    .period_end(period_end),
    .busy      (busy)
  );
  always #5 ck = ~ck;
  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: mode 0 idle, 1 running, 2 stopping; pos is the position within the period
  int m_mode, m_pos, m_per, m_duty, m_pp, m_pd;
  bit m_pend, m_acc, m_wrap, m_go;
  bit e_pwm, e_pe, e_busy, e_rdy = 1'b1;
  task automatic model_step();
    if (!rst_n) begin
      m_mode = 0; m_pos = 0; m_per = 0; m_duty = 0; m_pend = 0; m_pp = 0; m_pd = 0;
      e_pwm = 0; e_pe = 0; e_busy = 0; e_rdy = 1;
    end else begin
      m_acc  = cfg_valid && !m_pend;
      e_pwm  = m_mode != 0 && m_pos < m_duty;
      m_wrap = m_mode != 0 && m_pos == m_per;
      m_go   = m_mode == 0 && en;
      if (m_go) begin
        m_mode = 1;
        m_pos  = 0;
      end else if (m_mode != 0) begin
        m_pos  = m_wrap ? 0 : m_pos + 1;
        m_mode = en ? 1 : (m_mode == 2 && m_wrap) ? 0 : 2;
      end
      if ((m_go || m_wrap) && m_pend) begin
        m_per = m_pp; m_duty = m_pd; m_pend = 0;
      end
      if (m_acc) begin
        m_pend = 1; m_pp = int'(cfg_period); m_pd = int'(cfg_duty);
      end
      e_pe   = m_wrap;
      e_busy = m_mode != 0;
      e_rdy  = !m_pend;
    end
  endtask
  always @(posedge ck or negedge rst_n) model_step();
  always @(negedge ck) begin
    if (rst_n && started) begin
      chk("model_pwm_out", pwm_out, e_pwm);
      chk("model_period_end", period_end, e_pe);
      chk("model_busy", busy, e_busy);
      chk("model_cfg_ready", cfg_ready, e_rdy);
    end
  end
  task automatic cfg(input int p, input int d);
    int n;
    n = 0;
    while (!cfg_ready && n < 40) begin
      @(negedge ck);
      n++;
    end
    chk("cfg_slot_free", cfg_ready, 1);
    cfg_period = 8'(p);
    cfg_duty   = 8'(d);
    cfg_valid  = 1'b1;
    @(negedge ck);
    cfg_valid = 1'b0;
  endtask
  task automatic stop_wait();
    int n;
    n = 0;
    en = 1'b0;
    while (busy && n < 40) begin
      @(negedge ck);
      n++;
    end
    chk("stop_reached_idle", busy, 0);
  endtask
  task automatic wait_wrap(input string name);
    int n;
    n = 0;
    while (!period_end && n < 30) begin
      @(negedge ck);
      n++;
    end
    chk(name, period_end, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [19:0] pw, pe;
    logic [7:0]  bz;
    int          n, bad, hp, pc, bc;
    rst_n = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_duty = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_pwm_out", pwm_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_period_end", period_end, 0);
    repeat (2) @(negedge ck);
    rst_n = 1'b1;
    started = 1'b1;
    chk("reset_cfg_ready", cfg_ready, 1);
    // P=9 D=3 from idle: 3 high / 7 low, wrap pulse every 10 cycles
    cfg(9, 3);
    en = 1'b1;
    @(negedge ck);
    pw = '0; pe = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ck);
      pw = {pw[18:0], pwm_out};
      pe = {pe[18:0], period_end};
    end
    chk("p9d3_first_period", int'(pw[19:10]), int'(10'b1110000000));
    chk("p9d3_second_period", int'(pw[9:0]), int'(10'b1110000000));
    chk("p9d3_period_end", int'(pe), int'(20'b00000000010000000001));
    // Mid-period reconfiguration to P=4 D=4
    cfg(4, 4);
    chk("midcfg_ready_low", cfg_ready, 0);
    n = 0; bad = 0;
    while (!period_end && n < 20) begin
      @(negedge ck);
      n++;
      if (!period_end && cfg_ready) bad++;
    end
    chk("midcfg_wrap_seen", period_end, 1);
    chk("midcfg_wrap_cycle", n, 9);
    chk("midcfg_ready_held", bad, 0);
    chk("midcfg_ready_free", cfg_ready, 1);
    pw = '0; pe = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ck);
      pw = {pw[18:0], pwm_out};
      pe = {pe[18:0], period_end};
    end
    chk("p4d4_pwm", int'(pw[9:0]), int'(10'b1111011110));
    chk("p4d4_period_end", int'(pe[9:0]), int'(10'b0000100001));
    // Duty boundaries
    stop_wait();
    cfg(5, 0);
    en = 1'b1;
    @(negedge ck);
    hp = 0; bc = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge ck);
      hp += int'(pwm_out);
      bc += int'(busy);
    end
    chk("d0_pwm_high_count", hp, 0);
    chk("d0_busy_count", bc, 18);
    stop_wait();
    cfg(5, 7);
    en = 1'b1;
    @(negedge ck);
    hp = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge ck);
      hp += int'(pwm_out);
    end
    chk("d7_pwm_high_count", hp, 12);
    // P=0 D=1: every cycle wraps
    stop_wait();
    cfg(0, 1);
    en = 1'b1;
    @(negedge ck);
    hp = 0; pc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge ck);
      hp += int'(pwm_out);
      pc += int'(period_end);
    end
    chk("p0_pwm_count", hp, 8);
    chk("p0_period_end_count", pc, 8);
    // Stop request at cnt=2 of P=9
    stop_wait();
    cfg(9, 3);
    en = 1'b1;
    repeat (3) @(negedge ck);
    en = 1'b0;
    bz = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge ck);
      bz = {bz[6:0], busy};
    end
    chk("stop_busy_fall", int'(bz), int'(8'b11111110));
    chk("stop_pwm_low", pwm_out, 0);
    chk("stop_final_wrap", period_end, 1);
    bc = 0;
    repeat (3) begin
      @(negedge ck);
      bc += int'(busy);
    end
    chk("stop_stays_idle", bc, 0);
    // en dropped and re-raised within one period
    en = 1'b1;
    repeat (3) @(negedge ck);
    en = 1'b0;
    repeat (2) @(negedge ck);
    en = 1'b1;
    pw = '0; bc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ck);
      pw = {pw[18:0], pwm_out};
      bc += int'(busy);
    end
    chk("retoggle_pwm", int'(pw), int'(20'b00000011100000001110));
    chk("retoggle_busy", bc, 20);
    // Async reset in the high phase with a pending shadow
    wait_wrap("rst_wrap_seen");
    cfg(4, 4);
    chk("rst_pre_high", pwm_out, 1);
    chk("rst_pre_pending", cfg_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pwm_out", pwm_out, 0);
    chk("async_busy", busy, 0);
    chk("async_period_end", period_end, 0);
    chk("async_cfg_ready", cfg_ready, 1);
    @(negedge ck);
    rst_n = 1'b1;
    chk("post_rst_cfg_ready", cfg_ready, 1);
    @(negedge ck);
    hp = 0; pc = 0; bc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge ck);
      hp += int'(pwm_out);
      pc += int'(period_end);
      bc += int'(busy);
    end
    chk("post_rst_pwm_low", hp, 0);
    chk("post_rst_wrap_every_cycle", pc, 6);
    chk("post_rst_busy", bc, 6);
    stop_wait();
    repeat (2) @(negedge ck);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/pwm_ctrl.md
PWM_CTRL -- requirements
Module: pwm_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of the counter, period and duty values.
REQ-002 ck  input  1  single clock; all state updates on posedge ck.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  run request; 1 starts or continues PWM, 0 requests a stop at the end of the current period.
REQ-005 cfg_valid  input  1  new period/duty offered.
REQ-006 cfg_ready  output  1  shadow slot free; a config transfers on a cycle where cfg_valid and cfg_ready are both 1.
REQ-007 cfg_period  input  WIDTH  period value P; period length is P+1 cycles.
REQ-008 cfg_duty  input  WIDTH  high-time D in cycles.
REQ-009 pwm_out  output  1  registered PWM waveform.
REQ-010 period_end  output  1  registered one-cycle pulse on the cycle after the counter wraps.
REQ-011 busy  output  1  1 in RUN or STOP, 0 in IDLE.

Function
REQ-012 FSM states: IDLE, RUN and STOP. Transitions are IDLE->RUN when en=1, RUN->STOP when en=0, STOP->RUN when en=1 before the wrap, STOP->IDLE at the wrap.
REQ-013 Active registers: act_period and act_duty. Shadow registers: sh_period, sh_duty and the flag sh_full.
REQ-014 cfg_ready SHALL equal !sh_full. An accepted transfer writes the shadow registers and sets sh_full.
REQ-015 Shadow-to-active copy (clears sh_full) occurs only when the counter wraps or when leaving IDLE. It never occurs mid-period.
REQ-016 Simultaneous accept and wrap: the value already in the shadow is applied, and the newly accepted value is held for the next wrap. With sh_full=1 no accept is possible, so this reduces to sh_full=0: the new value goes to the shadow and is applied at the following wrap.
REQ-017 Counter cnt: cleared to 0 on IDLE->RUN. In RUN/STOP it increments each cycle and wraps to 0 when cnt==act_period.
REQ-018 pwm_out(t+1) = (state in RUN/STOP) and (cnt(t) < act_duty(t)). Latency is one cycle from cnt to pwm_out.
REQ-019 Duty boundaries:
  - D=0 gives pwm_out constantly 0.
  - D>P gives pwm_out constantly 1 while running.
  - No glitch at the wrap.
REQ-020 P=0: cnt stays 0, every cycle is a wrap, period_end is high continuously, and the shadow applies every cycle.
REQ-021 period_end(t+1)=1 iff the wrap occurred at cycle t in RUN/STOP.
REQ-022 In IDLE: pwm_out=0, cnt holds 0, and the shadow may still accept one config.
REQ-023 en toggled 1->0->1 within one period: the waveform continues uninterrupted, with no counter reset.
REQ-024 All arithmetic is unsigned WIDTH-bit. The compare is unsigned. The counter never exceeds act_period.

Reset
REQ-025 On rst_n=0, immediately and independent of ck, the block SHALL enter this state:
  - state=IDLE, cnt=0
  - act_period=0, act_duty=0
  - sh_period=0, sh_duty=0, sh_full=0
  - pwm_out=0, period_end=0, busy=0
  - cfg_ready=1 once reset is released
REQ-026 Reset asserted mid-period SHALL abort the waveform and discard any pending shadow config.
REQ-027 The first active edge after rst_n rises SHALL behave as a normal cycle.

Structure
REQ-028 Shared package pwm_pkg SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, STOP=2'd2) and the default WIDTH constant.
REQ-029 One sub-module pwm_shadow_reg SHALL implement the shadow registers, sh_full and the handshake. The FSM, counter and compare SHALL stay in pwm_ctrl.
REQ-030 All outputs SHALL be driven directly from flops.

Verification
REQ-031 WIDTH=8, cfg P=9 D=3 accepted in IDLE, then en=1 -> pwm_out SHALL be high for 3 cycles and low for 7, with period_end pulsing every 10 cycles.
REQ-032 While running P=9 D=3, cfg P=4 D=4 accepted mid-period -> the current period SHALL complete unchanged, and the next period SHALL be 5 cycles with pwm_out high for 4. cfg_ready SHALL be 0 from accept until the wrap.
REQ-033 Duty boundaries -> D=0 P=5 SHALL give pwm_out always 0. D=7 P=5 SHALL give pwm_out always 1 while busy=1.
REQ-034 P=0 D=1 -> pwm_out SHALL be constantly 1 and period_end constantly 1 after start.
REQ-035 en dropped at cnt=2 of P=9 -> the period SHALL finish, busy SHALL fall the cycle after the wrap, and pwm_out SHALL be 0. Re-raising en before the wrap SHALL give no gap.
REQ-036 rst_n pulsed low mid-high-phase with a pending shadow -> pwm_out SHALL go 0 asynchronously. After release, cfg_ready=1 and en=1 SHALL run with act_period=0 and act_duty=0 (output low).
